// File: rtl/prog_loader.sv
// prog_loader: pin-driven byte loader that takes ownership of a 16x8 program
// RAM, writes one byte per wr_strobe rising edge and optionally reads it back.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   prog_mode       async pin: request program mode (synchronized)
//   wr_strobe       async pin: one rising edge = one byte (synchronized)
//   auto_inc        1 = internal pointer supplies address, 0 = addr_in
//   addr_in/data_in address/data, sampled on a detected strobe edge
//   ram_rdata       RAM read data, one clk after ram_addr
//   ram_we/ram_addr/ram_wdata  RAM write port
//   cpu_halt        CPU clock-enable hold while the loader owns the RAM
//   busy/ack/err    status; err is a sticky readback mismatch
//   byte_count      bytes written this session, saturating at 16
module prog_loader #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned VERIFY_EN   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prog_mode,
  input  logic       wr_strobe,
  input  logic       auto_inc,
  input  logic [3:0] addr_in,
  input  logic [7:0] data_in,
  input  logic [7:0] ram_rdata,
  output logic       ram_we,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       cpu_halt,
  output logic       busy,
  output logic       ack,
  output logic       err,
  output logic [4:0] byte_count
);

  localparam int unsigned AW = 4;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] CNT_MAX = CW'(16);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WRITE,
    S_VERIFY,
    S_ACK
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] pm_sync_q, ws_sync_q;
  logic          pm_s, ws_s, ws_prev_q;
  logic          strobe_edge_c;
  logic [AW-1:0] ptr_q, ptr_d, addr_d;
  logic [7:0]    wdata_d;
  logic [CW-1:0] cnt_d;
  logic          err_d;
  logic          ainc_q, ainc_d;
  logic          vphase_q, vphase_d;

  assign pm_s          = pm_sync_q[SYNC_STAGES-1];
  assign ws_s          = ws_sync_q[SYNC_STAGES-1];
  assign strobe_edge_c = ws_s & ~ws_prev_q;

  // Pin synchronizers and strobe edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_sync_q <= '0;
      ws_sync_q <= '0;
      ws_prev_q <= 1'b0;
    end else begin
      pm_sync_q <= {pm_sync_q[SYNC_STAGES-2:0], prog_mode};
      ws_sync_q <= {ws_sync_q[SYNC_STAGES-2:0], wr_strobe};
      ws_prev_q <= ws_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath updates
  always_comb begin
    state_d  = state_q;
    addr_d   = ram_addr;
    wdata_d  = ram_wdata;
    ptr_d    = ptr_q;
    cnt_d    = byte_count;
    err_d    = err;
    ainc_d   = ainc_q;
    vphase_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pm_s) begin
          state_d = S_ARMED;
          ptr_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_ARMED: begin
        // A strobe edge wins over a simultaneous prog_mode drop
        if (strobe_edge_c) begin
          addr_d  = auto_inc ? ptr_q : addr_in;
          wdata_d = data_in;
          ainc_d  = auto_inc;
          state_d = S_WRITE;
        end else if (!pm_s) begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (ainc_q) ptr_d = ptr_q + AW'(1);
        if (byte_count != CNT_MAX) cnt_d = byte_count + CW'(1);
        state_d = (VERIFY_EN != 0) ? S_VERIFY : S_ACK;
      end
      S_VERIFY: begin
        // First cycle waits out the synchronous read latency
        if (!vphase_q) begin
          vphase_d = 1'b1;
        end else begin
          if (ram_rdata != ram_wdata) err_d = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!ws_s) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers; status outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ptr_q      <= '0;
      byte_count <= '0;
      err        <= 1'b0;
      ainc_q     <= 1'b0;
      vphase_q   <= 1'b0;
      ram_we     <= 1'b0;
      busy       <= 1'b0;
      ack        <= 1'b0;
      cpu_halt   <= 1'b0;
    end else begin
      ram_addr   <= addr_d;
      ram_wdata  <= wdata_d;
      ptr_q      <= ptr_d;
      byte_count <= cnt_d;
      err        <= err_d;
      ainc_q     <= ainc_d;
      vphase_q   <= vphase_d;
      ram_we     <= (state_d == S_WRITE);
      busy       <= (state_d == S_WRITE) || (state_d == S_VERIFY);
      ack        <= (state_d == S_ACK);
      cpu_halt   <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: RAM model, write scoreboard and scenario tasks.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_mode, wr_strobe, auto_inc;
  logic [3:0] addr_in;
  logic [7:0] data_in;
  logic [7:0] ram_rdata;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_halt, busy, ack, err;
  logic [4:0] byte_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem [16];
  logic        corrupt = 1'b0;
  logic [11:0] exp_q [$];
  logic [11:0] obs_q [$];
  logic [3:0]  model_ptr;
  logic [4:0]  model_cnt;

  prog_loader #(.SYNC_STAGES(2), .VERIFY_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode), .wr_strobe(wr_strobe),
    .auto_inc(auto_inc), .addr_in(addr_in), .data_in(data_in),
    .ram_rdata(ram_rdata), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .cpu_halt(cpu_halt), .busy(busy), .ack(ack),
    .err(err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM; corrupt flips bit 0 of the read data
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr] ^ {7'b0, corrupt};
  end

  // Capture each write pulse for the scoreboard
  always @(negedge clk) begin
    if (ram_we === 1'b1) obs_q.push_back({ram_addr, ram_wdata});
  end

  task automatic wait_ack(input logic level, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (ack === level) return;
      @(negedge clk);
    end
    n_checks++; n_fail++;
    $display("FAIL %s: ack timeout, ack=%b required %b", tag, ack, level);
  endtask

  task automatic wait_halt(input logic level, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (cpu_halt === level) return;
      @(negedge clk);
    end
    n_checks++; n_fail++;
    $display("FAIL %s: cpu_halt timeout, cpu_halt=%b required %b", tag, cpu_halt, level);
  endtask

  task automatic wait_we(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (ram_we === 1'b1) return;
      @(negedge clk);
    end
    n_checks++; n_fail++;
    $display("FAIL %s: ram_we timeout", tag);
  endtask

  // One strobe transaction; expected write pushed at stimulus, checked after ack
  task automatic do_write(input logic [7:0] d, input logic [3:0] a, input logic ai, input string tag);
    logic [11:0] e, o;
    @(negedge clk);
    data_in = d; addr_in = a; auto_inc = ai; wr_strobe = 1'b1;
    exp_q.push_back({ai ? model_ptr : a, d});
    if (ai) model_ptr = model_ptr + 4'd1;
    if (model_cnt != 5'd16) model_cnt = model_cnt + 5'd1;
    wait_ack(1'b1, tag);
    wr_strobe = 1'b0;
    wait_ack(1'b0, tag);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_q.size() !== 1) begin
      n_fail++;
      $display("FAIL %s: write pulses got %0d required 1", tag, obs_q.size());
    end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: write addr/data got %h required %h", tag, o, e);
      end
    end
    obs_q.delete();
  endtask

  task automatic enter_session(input string tag);
    @(negedge clk);
    prog_mode = 1'b1;
    wait_halt(1'b1, tag);
    model_ptr = 4'd0;
    model_cnt = 5'd0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; prog_mode = 1'b0; wr_strobe = 1'b0; auto_inc = 1'b0;
    addr_in = '0; data_in = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ram_we, ram_addr, ram_wdata, cpu_halt, busy, ack, err, byte_count} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {ram_we, ram_addr, ram_wdata, cpu_halt, busy, ack, err, byte_count});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (cpu_halt !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_halt: cpu_halt got %b required 0", cpu_halt);
    end
  endtask

  task automatic test_auto_inc;
    enter_session("auto_enter");
    n_checks++;
    if (busy !== 1'b0 || ack !== 1'b0) begin
      n_fail++;
      $display("FAIL armed_status: busy=%b ack=%b required 0 0", busy, ack);
    end
    for (int i = 0; i < 16; i++) do_write(8'h10 + 8'(i), 4'hF, 1'b1, "auto_write");
    n_checks++;
    if (byte_count !== 5'd16) begin
      n_fail++;
      $display("FAIL auto_count: got %0d required 16", byte_count);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_err: got %b required 0", err);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (mem[i] !== 8'h10 + 8'(i)) begin
        n_fail++;
        $display("FAIL auto_mem[%0d]: got %h required %h", i, mem[i], 8'h10 + 8'(i));
      end
    end
    // Pointer wrapped to 0; count stays saturated
    do_write(8'h99, 4'h5, 1'b1, "wrap_write");
    n_checks++;
    if (byte_count !== 5'd16) begin
      n_fail++;
      $display("FAIL count_sat: got %0d required 16", byte_count);
    end
  endtask

  task automatic test_explicit;
    do_write(8'hA5, 4'h7, 1'b0, "explicit_write");
    n_checks++;
    if (ram_addr !== 4'h7 || mem[7] !== 8'hA5) begin
      n_fail++;
      $display("FAIL explicit_hold: addr=%h mem7=%h required 7 a5", ram_addr, mem[7]);
    end
  endtask

  task automatic test_held_strobe;
    int pulses = 0;
    logic [11:0] o;
    @(negedge clk);
    data_in = 8'h5A; addr_in = 4'h2; auto_inc = 1'b0; wr_strobe = 1'b1;
    exp_q.push_back({4'h2, 8'h5A});
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ram_we === 1'b1) pulses++;
    end
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL held_ack: got %b required 1", ack);
    end
    wr_strobe = 1'b0;
    wait_ack(1'b0, "held_release");
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL held_pulses: got %0d required 1", pulses);
    end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_checks++;
      if (o !== exp_q[0]) begin
        n_fail++;
        $display("FAIL held_write: got %h required %h", o, exp_q[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_verify_fail;
    corrupt = 1'b1;
    do_write(8'h3C, 4'h3, 1'b0, "verify_bad");
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL verify_err_set: got %b required 1", err);
    end
    corrupt = 1'b0;
    do_write(8'h42, 4'h4, 1'b0, "verify_good");
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL verify_err_sticky: got %b required 1", err);
    end
    @(negedge clk);
    prog_mode = 1'b0;
    wait_halt(1'b0, "verify_exit");
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL verify_err_idle: got %b required 1", err);
    end
    enter_session("verify_reenter");
    n_checks++;
    if (err !== 1'b0 || byte_count !== 5'd0) begin
      n_fail++;
      $display("FAIL verify_clear: err=%b count=%0d required 0 0", err, byte_count);
    end
  endtask

  task automatic test_exit_mid;
    logic [11:0] o;
    @(negedge clk);
    data_in = 8'h77; addr_in = 4'h9; auto_inc = 1'b0; wr_strobe = 1'b1;
    exp_q.push_back({4'h9, 8'h77});
    wait_we("exit_we");
    prog_mode = 1'b0;
    wait_ack(1'b1, "exit_ack");
    n_checks++;
    if (cpu_halt !== 1'b1) begin
      n_fail++;
      $display("FAIL exit_halt_ack: got %b required 1", cpu_halt);
    end
    wr_strobe = 1'b0;
    wait_halt(1'b0, "exit_idle");
    n_checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL exit_status: ack=%b busy=%b required 0 0", ack, busy);
    end
    n_checks++;
    if (obs_q.size() !== 1) begin
      n_fail++;
      $display("FAIL exit_pulses: got %0d required 1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_checks++;
      if (o !== exp_q[0]) begin
        n_fail++;
        $display("FAIL exit_write: got %h required %h", o, exp_q[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_async_reset;
    int pulses = 0;
    enter_session("rst_enter");
    @(negedge clk);
    data_in = 8'hEE; addr_in = 4'h5; auto_inc = 1'b0; wr_strobe = 1'b1;
    wait_we("rst_we");
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_verify: busy=%b we=%b required 1 0", busy, ram_we);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ram_we, ram_addr, ram_wdata, cpu_halt, busy, ack, err, byte_count} !== 22'd0) begin
      n_fail++;
      $display("FAIL rst_async: got %h required 0",
               {ram_we, ram_addr, ram_wdata, cpu_halt, busy, ack, err, byte_count});
    end
    obs_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cpu_halt !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_resync: cpu_halt got %b required 0", cpu_halt);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_we === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || cpu_halt !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_no_write: pulses=%0d halt=%b required 0 1", pulses, cpu_halt);
    end
    wr_strobe = 1'b0;
    repeat (4) @(negedge clk);
    obs_q.delete();
    do_write(8'h31, 4'h1, 1'b0, "rst_after_write");
  endtask

  initial begin
    test_reset();
    test_auto_inc();
    test_explicit();
    test_held_strobe();
    test_verify_fail();
    test_exit_mid();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of flip-flop stages in each pin synchronizer (minimum 2).
REQ-002 SHALL have parameter VERIFY_EN, default 1; 1 = read back and compare every written byte, 0 = skip readback.
REQ-003 clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 prog_mode  input  1  pin-level request for program mode; asynchronous to clk.
REQ-006 wr_strobe  input  1  pin-level write strobe; asynchronous; one rising edge = one byte.
REQ-007 auto_inc  input  1  1 = use the internal address pointer; 0 = use addr_in.
REQ-008 addr_in  input  4  explicit RAM address; sampled only on a detected strobe edge.
REQ-009 data_in  input  8  byte to write; sampled only on a detected strobe edge.
REQ-010 ram_rdata  input  8  RAM read data; valid one clk after ram_addr is presented (synchronous read).
REQ-011 ram_we  output  1  RAM write enable; single-cycle pulse.
REQ-012 ram_addr  output  4  RAM address.
REQ-013 ram_wdata  output  8  RAM write data.
REQ-014 cpu_halt  output  1  holds the CPU clock-enable off while the loader owns the RAM.
REQ-015 busy  output  1  high in WRITE and VERIFY.
REQ-016 ack  output  1  high in ACK.
REQ-017 err  output  1  sticky readback-mismatch flag.
REQ-018 byte_count  output  5  number of bytes written this session; saturates at 16.

Function
REQ-019 SHALL pass prog_mode and wr_strobe each through a SYNC_STAGES flip-flop synchronizer; data_in, addr_in and auto_inc SHALL NOT be synchronized.
REQ-020 SHALL detect a strobe edge as synchronized wr_strobe = 1 with its previous sampled value = 0.
REQ-021 FSM states SHALL be IDLE, ARMED, WRITE, VERIFY, ACK, encoded one-hot or binary.
REQ-022 In IDLE, synced prog_mode = 1 SHALL move the FSM to ARMED next cycle, and SHALL clear the pointer, byte_count and err.
REQ-023 In ARMED, a strobe edge SHALL latch data_in, plus addr_in when auto_inc = 0 or the pointer when auto_inc = 1, into the address/data registers, then go to WRITE.
REQ-024 In ARMED, synced prog_mode = 0 with no strobe edge SHALL return the FSM to IDLE; a strobe edge in the same cycle SHALL take priority.
REQ-025 WRITE SHALL assert ram_we for exactly one cycle with the latched ram_addr and ram_wdata, then go to VERIFY if VERIFY_EN = 1, else to ACK.
REQ-026 VERIFY SHALL last 2 cycles with ram_addr held; in the second cycle, ram_rdata != ram_wdata SHALL set err, and the FSM SHALL then go to ACK.
REQ-027 On leaving WRITE, the pointer SHALL increment when auto_inc was 1 at latch time, wrapping 15 -> 0; byte_count SHALL increment, saturating at 16.
REQ-028 ACK SHALL hold ack = 1 until synced wr_strobe = 0, then return to ARMED, so a held strobe produces exactly one write.
REQ-029 prog_mode falling during WRITE, VERIFY or ACK SHALL NOT abort the transaction; the FSM SHALL reach ARMED and then exit to IDLE.
REQ-030 cpu_halt SHALL be 1 in every state except IDLE.
REQ-031 Outside WRITE and VERIFY, ram_addr SHALL hold its last value and ram_we SHALL be 0.
REQ-032 A strobe edge arriving in WRITE, VERIFY or ACK SHALL be ignored; it SHALL NOT be queued.
REQ-033 err SHALL remain set until the next IDLE -> ARMED entry or reset.

Reset
REQ-034 rst_n = 0 SHALL asynchronously force: FSM = IDLE, every synchronizer stage = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, cpu_halt = 0, busy = 0, ack = 0, err = 0, byte_count = 0, pointer = 0.
REQ-035 Reset asserted mid-WRITE SHALL drop ram_we in the same cycle, with no completion.
REQ-036 After rst_n deasserts, the first operation SHALL require prog_mode to pass through the synchronizer again.

Verification
REQ-037 Auto-increment: prog_mode = 1, auto_inc = 1, 16 strobes with data 0x10..0x1F -> RAM[0..15] = 0x10..0x1F, byte_count = 16, pointer = 0 after wrap, err = 0.
REQ-038 Explicit address: auto_inc = 0, addr_in = 0x7, data_in = 0xA5, one strobe -> exactly one ram_we pulse at address 7 with 0xA5; ack rises, then falls after the strobe is released.
REQ-039 Held strobe: wr_strobe held high for 50 cycles -> exactly one ram_we pulse.
REQ-040 Verify fail: RAM model corrupts bit 0 on readback, write 0x3C -> err = 1 and stays set through further writes until the next IDLE -> ARMED entry.
REQ-041 Exit mid-transaction: prog_mode drops in the WRITE cycle -> write completes, ACK completes, then IDLE with cpu_halt = 0.
REQ-042 Async reset: rst_n pulsed low during VERIFY -> all outputs 0 immediately, and no further ram_we until prog_mode is re-synchronized.
